// File: rtl/dut_capture.sv
`default_nettype none
// ============================================================================
//  Module      : dut_capture
//  Description : Capture stage in front of the result checker. Pops one
//                stimulus word {stim, expect, max_wait} from STIM_FIFO and
//                drives stim onto the DUT inputs. It then compares the DUT
//                outputs every cycle until they equal expect or the wait
//                window runs out. Finally it pushes {result, cycles, timeout}
//                into RES_FIFO. Only one vector is in flight at a time.
//
//  Ports       : clock          - single clock
//                reset          - synchronous, active-high
//                sfifo_data     - stimulus word, MSB first {stim, expect, max_wait}
//                sfifo_rdreq    - STIM_FIFO pop (non-show-ahead, data next cycle)
//                sfifo_rdempty  - STIM_FIFO empty
//                dut_in         - registered drive to DUT inputs
//                dut_out        - DUT outputs
//                rfifo_data     - result word {result, cycles, timeout}
//                rfifo_wrreq    - RES_FIFO push
//                rfifo_wrfull   - RES_FIFO full
//                busy           - high whenever the FSM is not in IDLE
//
//  Config      : DUT_OUT_SYNC_EN - when defined, dut_out passes a 2-flop
//                synchronizer before the compare point. The reported cycle
//                count then includes those two flops.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dut_capture #(
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5,
    parameter int SFF_WIDTH   = 2*RTF_WIDTH+CYCLE_RANGE
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [SFF_WIDTH-1:0]             sfifo_data,
    output logic                             sfifo_rdreq,
    input  logic                             sfifo_rdempty,
    output logic [RTF_WIDTH-1:0]             dut_in,
    input  logic [RTF_WIDTH-1:0]             dut_out,
    output logic [RTF_WIDTH+CYCLE_RANGE:0]   rfifo_data,
    output logic                             rfifo_wrreq,
    input  logic                             rfifo_wrfull,
    output logic                             busy
);

    localparam logic [CYCLE_RANGE-1:0] c_COUNT_ONE = {{(CYCLE_RANGE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_LOAD = 2'd1,
        c_ST_WAIT = 2'd2,
        c_ST_PUSH = 2'd3
    } state_t;

    state_t                           r_state;
    logic [RTF_WIDTH-1:0]             r_dut_in;
    logic [RTF_WIDTH-1:0]             r_expect;
    logic [CYCLE_RANGE-1:0]           r_max_wait;
    logic [CYCLE_RANGE-1:0]           r_count;
    logic [RTF_WIDTH+CYCLE_RANGE:0]   r_rfifo_data;

    logic [RTF_WIDTH-1:0]             w_cmp;
    logic                             w_pop;
    logic                             w_push;

    // Compare-point value of the DUT outputs
`ifdef DUT_OUT_SYNC_EN
    logic [RTF_WIDTH-1:0] r_sync1;
    logic [RTF_WIDTH-1:0] r_sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cmp = r_sync2;
`else
    assign w_cmp = dut_out;
`endif

    // Handshakes are combinational so a pop/push happens in the same cycle
    // the FIFO flag allows it. Both are gated by reset so that no word is
    // lost or pushed while the FSM is being forced back to IDLE.
    assign w_pop  = (r_state == c_ST_IDLE) && !sfifo_rdempty && !reset;
    assign w_push = (r_state == c_ST_PUSH) && !rfifo_wrfull  && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_dut_in     <= '0;
            r_expect     <= '0;
            r_max_wait   <= '0;
            r_count      <= '0;
            r_rfifo_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    // Popped word is valid this cycle (non-show-ahead FIFO)
                    r_dut_in   <= sfifo_data[SFF_WIDTH-1 -: RTF_WIDTH];
                    r_expect   <= sfifo_data[CYCLE_RANGE +: RTF_WIDTH];
                    r_max_wait <= sfifo_data[CYCLE_RANGE-1:0];
                    r_count    <= '0;
                    r_state    <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // Match is tested first so it wins over a simultaneous timeout
                    if (w_cmp == r_expect) begin
                        r_rfifo_data <= {w_cmp, r_count, 1'b0};
                        r_state      <= c_ST_PUSH;
                    end else if (r_count == r_max_wait) begin
                        r_rfifo_data <= {w_cmp, r_count, 1'b1};
                        r_state      <= c_ST_PUSH;
                    end else begin
                        // Cannot wrap: r_max_wait fits in CYCLE_RANGE bits
                        r_count <= r_count + c_COUNT_ONE;
                    end
                end
                c_ST_PUSH: begin
                    if (w_push) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sfifo_rdreq = w_pop;
    assign rfifo_wrreq = w_push;
    assign dut_in      = r_dut_in;
    assign rfifo_data  = r_rfifo_data;
    assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dut_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dut_capture
//  Description : Self-checking bench for dut_capture (default build). It uses
//                a table of directed vectors, and each vector carries a DUT
//                response pattern plus the hand-computed result word and
//                push latency. Hand-written sequences cover reset and
//                reset-during-wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dut_capture;

    localparam int c_RTF = 24;
    localparam int c_CR  = 5;
    localparam int c_SFF = 2*c_RTF+c_CR;
    localparam int c_RES = c_RTF+c_CR+1;

    logic               clock = 1'b0;
    logic               reset;
    logic [c_SFF-1:0]   sfifo_data;
    logic               sfifo_rdreq;
    logic               sfifo_rdempty;
    logic [c_RTF-1:0]   dut_in;
    logic [c_RTF-1:0]   dut_out;
    logic [c_RES-1:0]   rfifo_data;
    logic               rfifo_wrreq;
    logic               rfifo_wrfull;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [c_RTF-1:0] last_stim = '0;

    always #5 clock = ~clock;

    dut_capture #(
        .RTF_WIDTH   (c_RTF),
        .CYCLE_RANGE (c_CR),
        .SFF_WIDTH   (c_SFF)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .sfifo_data    (sfifo_data),
        .sfifo_rdreq   (sfifo_rdreq),
        .sfifo_rdempty (sfifo_rdempty),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .rfifo_data    (rfifo_data),
        .rfifo_wrreq   (rfifo_wrreq),
        .rfifo_wrfull  (rfifo_wrfull),
        .busy          (busy)
    );

    // delay < 0: DUT never produces the expected value.
    // Otherwise dut_out == expv from delay cycles after dut_in is applied.
    // Before that it shows other + cycle index.
    typedef struct {
        logic [c_RTF-1:0] stim;
        logic [c_RTF-1:0] expv;
        logic [c_RTF-1:0] other;
        int               max_wait;
        int               delay;
        int               stall;
        logic [c_RTF-1:0] exp_res;
        int               exp_cyc;
        logic             exp_to;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit               seen;
        bit               bad_pop;
        int               at;
        logic [c_RES-1:0] exp_word;
        exp_word = {v.exp_res, v.exp_cyc[c_CR-1:0], v.exp_to};
        seen     = 1'b0;
        bad_pop  = 1'b0;
        at       = -1;
        // Cycle T: word available, pop must be combinational
        @(negedge clock);
        sfifo_rdempty = 1'b0;
        #1 check($sformatf("v%0d_rdreq", idx), 64'(sfifo_rdreq), 64'd1);
        // Cycle T+1: LOAD, FIFO presents popped data
        @(negedge clock);
        sfifo_rdempty = 1'b1;
        sfifo_data    = {v.stim, v.expv, v.max_wait[c_CR-1:0]};
        #1;
        check($sformatf("v%0d_busy_load", idx), 64'(busy), 64'd1);
        check($sformatf("v%0d_dut_in_held", idx), 64'(dut_in), 64'(last_stim));
        // Cycles T+2 onward: index cyc equals the WAIT count while waiting
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            @(negedge clock);
            dut_out       = (v.delay >= 0 && cyc >= v.delay) ? v.expv : v.other + c_RTF'(cyc);
            rfifo_wrfull  = (cyc > v.exp_cyc) && (cyc <= v.exp_cyc + v.stall);
            sfifo_rdempty = 1'b0;   // a further word waits; it must not be popped
            #1;
            if (cyc == 0) check($sformatf("v%0d_dut_in", idx), 64'(dut_in), 64'(v.stim));
            if (sfifo_rdreq) bad_pop = 1'b1;
            if (rfifo_wrfull) begin
                check($sformatf("v%0d_stall_wrreq", idx), 64'(rfifo_wrreq), 64'd0);
                check($sformatf("v%0d_stall_data", idx), 64'(rfifo_data), 64'(exp_word));
            end
            if (rfifo_wrreq) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        sfifo_rdempty = 1'b1;
        rfifo_wrfull  = 1'b0;
        check($sformatf("v%0d_no_pop_busy", idx), 64'(bad_pop), 64'd0);
        check($sformatf("v%0d_push_latency", idx), 64'(at), 64'(v.exp_cyc + 1 + v.stall));
        check($sformatf("v%0d_rfifo_data", idx), 64'(rfifo_data), 64'(exp_word));
        @(negedge clock);
        #1 check($sformatf("v%0d_idle_after", idx), 64'(busy), 64'd0);
        last_stim = v.stim;
    endtask

    initial begin
        bit bad_push;
        // stim, expv, other, max_wait, delay, stall, exp_res, exp_cyc, exp_to
        vecs[0] = '{24'hA5A5A5, 24'h00FF00, 24'h123456,  5,  0, 0, 24'h00FF00,  0, 1'b0};
        vecs[1] = '{24'h111111, 24'hABCDEF, 24'h000100, 10,  3, 0, 24'hABCDEF,  3, 1'b0};
        vecs[2] = '{24'h222222, 24'hFFFFFF, 24'h000010,  4, -1, 0, 24'h000014,  4, 1'b1};
        vecs[3] = '{24'h333333, 24'h0F0F0F, 24'h000200,  0, -1, 0, 24'h000200,  0, 1'b1};
        vecs[4] = '{24'h444444, 24'h5A5A5A, 24'h000001,  3,  3, 0, 24'h5A5A5A,  3, 1'b0};
        vecs[5] = '{24'h555555, 24'h0000AA, 24'h000000,  2,  1, 6, 24'h0000AA,  1, 1'b0};
        vecs[6] = '{24'h666666, 24'hC0FFEE, 24'h001000, 31, -1, 0, 24'h00101F, 31, 1'b1};

        reset         = 1'b1;
        sfifo_data    = '0;
        sfifo_rdempty = 1'b1;
        dut_out       = '0;
        rfifo_wrfull  = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_dut_in", 64'(dut_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdreq", 64'(sfifo_rdreq), 64'd0);
        check("rst_wrreq", 64'(rfifo_wrreq), 64'd0);
        check("rst_rfifo_data", 64'(rfifo_data), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while waiting at count 2: vector abandoned, no push
        @(negedge clock);
        sfifo_rdempty = 1'b0;
        @(negedge clock);
        sfifo_rdempty = 1'b1;
        sfifo_data    = {24'h777777, 24'hABABAB, 5'd10};
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            dut_out = 24'h000040 + c_RTF'(cyc);
            if (cyc == 2) reset = 1'b1;
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("wrst_dut_in", 64'(dut_in), 64'd0);
        check("wrst_busy", 64'(busy), 64'd0);
        check("wrst_rfifo_data", 64'(rfifo_data), 64'd0);
        bad_push = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clock);
            #1 if (rfifo_wrreq || busy) bad_push = 1'b1;
        end
        check("wrst_no_push", 64'(bad_push), 64'd0);
        last_stim = '0;
        run_vec(vecs[1], 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
